fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: RESET_PC, 8'd0, word address loaded into pc on reset and on start.
REQ-002 Parameter: CNT_W, 16, width of retired-fetch counter.
REQ-003 Port: clk  input  1  single clock, all state updates on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  IDLE->FETCH request (level sampled at posedge).
REQ-006 Port: stop  input  1  FETCH->IDLE request.
REQ-007 Port: stall  input  1  consumer not accepting current instr.
REQ-008 Port: redirect, redirect_addr  input  1, 8  branch/jump target, flushes in-flight fetch.
REQ-009 Port: load_req, load_addr, load_data  input  1, 8, 32  program-load write request.
REQ-010 Port: load_ack  output  1  write performed this cycle.
REQ-011 Port: mem_addr, mem_wdata, mem_we  output  8, 32, 1  instruction memory port.
REQ-012 Port: mem_rdata  input  32  memory read data, valid one cycle after mem_addr (synchronous read).
REQ-013 Port: instr, instr_pc, instr_valid  output  32, 8, 1  fetched instruction, its address, qualifier.
REQ-014 Port: busy  output  1  high in FETCH or LOAD.
REQ-015 Port: fetch_count  output  CNT_W  instructions accepted since reset.

Function
REQ-016 States SHALL be IDLE, FETCH, LOAD; internal registers pc[7:0], pend_valid, pend_pc[7:0].
REQ-017 IDLE: load_req=1 -> LOAD; else start=1 -> FETCH with pc<=RESET_PC, pend_valid<=0; load_req wins when both high.
REQ-018 LOAD: each cycle with load_req=1 -> mem_we=1, mem_addr=load_addr, mem_wdata=load_data, load_ack=1 (combinational, same cycle); load_req=0 -> IDLE, mem_we=0.
REQ-019 load_req in FETCH SHALL be ignored (load_ack=0) until FETCH exits.
REQ-020 FETCH issue address: mem_addr = pend_pc when (stall & pend_valid), else pc; mem_we=0.
REQ-021 FETCH, no redirect, no hold: pend_pc<=mem_addr, pend_valid<=1, pc<=pc+1 (8-bit wrap 255->0).
REQ-022 Hold (stall & pend_valid): pc unchanged, pend_pc re-issued, pend_valid stays 1; instr/instr_pc stable next cycle.
REQ-023 instr=mem_rdata, instr_pc=pend_pc, instr_valid=pend_valid & (state==FETCH); combinational.
REQ-024 redirect (priority over stall and stop): pc<=redirect_addr+0, pend_valid<=0; next cycle mem_addr=redirect_addr, instr_valid=0; first redirected instr valid two cycles after redirect.
REQ-025 stop in FETCH (no redirect): -> IDLE, pend_valid<=0, pc retained; stop and redirect together: redirect applied, stop applied next cycle if still high.
REQ-026 Accept = instr_valid & ~stall & ~redirect; fetch_count += 1 per accept, saturating at all-ones.
REQ-027 IDLE: mem_addr=pc, mem_we=0, load_ack=0, instr_valid=0.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 reset=1 at posedge SHALL force state IDLE, pc=RESET_PC, pend_valid=0, pend_pc=0, fetch_count=0, regardless of state.
REQ-030 During/after reset: mem_we=0, load_ack=0, instr_valid=0, busy=0; reset mid-LOAD drops in-progress write (no mem_we in reset cycle); reset overrides start/load_req.

Verification
REQ-031 Load: IDLE, load_req 3 cycles addr 0,1,2 data 0x38010005/0x38020009/0x00221826 -> mem_we & load_ack 3 cycles, matching addr/data; then IDLE.
REQ-032 Sequential fetch: start, no stall -> instr_valid from cycle 2, instr_pc 0,1,2,... one per cycle, fetch_count increments each cycle.
REQ-033 Stall: stall high 3 cycles while instr_pc=4 -> instr_pc held 4, mem_addr=4, fetch_count unchanged; release -> 5 next.
REQ-034 Redirect: redirect_addr=7 while instr_pc=10 -> next cycle instr_valid=0, then instr_pc 7,8,...
REQ-035 Wrap/boundary: start from pc=254 (via redirect 254) -> instr_pc 254,255,0; fetch_count saturation with CNT_W forced small holds at max.
REQ-036 Reset mid-FETCH and mid-LOAD -> next cycle IDLE, instr_valid=0, mem_we=0, fetch_count=0; start+load_req together in IDLE -> LOAD.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: program-load writes into instruction memory, then
// sequential fetch with stall hold, redirect flush, and a saturating accept counter.
module fetch_controller #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             stall,
  input  logic             redirect,
  input  logic [7:0]       redirect_addr,
  input  logic             load_req,
  input  logic [7:0]       load_addr,
  input  logic [31:0]      load_data,
  output logic             load_ack,
  output logic [7:0]       mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      instr,
  output logic [7:0]       instr_pc,
  output logic             instr_valid,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold;
  logic             writing;
  logic             accept;

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  always_comb begin
    hold        = stall & pend_valid_q;
    writing     = (state_q == S_LOAD) & load_req & ~reset;
    mem_we      = writing;
    load_ack    = writing;
    mem_wdata   = load_data;
    instr       = mem_rdata;
    instr_pc    = pend_pc_q;
    instr_valid = pend_valid_q & (state_q == S_FETCH) & ~reset;
    busy        = (state_q != S_IDLE) & ~reset;
    accept      = instr_valid & ~stall & ~redirect;
    fetch_count = cnt_q;
    case (state_q)
      S_FETCH: mem_addr = hold ? pend_pc_q : pc_q;
      S_LOAD:  mem_addr = load_req ? load_addr : pc_q;
      default: mem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    cnt_d        = (accept && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
        end else if (start) begin
          state_d      = S_FETCH;
          pc_d         = RESET_PC;
          pend_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!load_req) state_d = S_IDLE;
      end
      S_FETCH: begin
        // Redirect outranks stop; a held stop takes effect the following cycle.
        if (redirect) begin
          pc_d         = redirect_addr;
          pend_valid_d = 1'b0;
        end else if (stop) begin
          state_d      = S_IDLE;
          pend_valid_d = 1'b0;
        end else if (!hold) begin
          pend_pc_d    = mem_addr;
          pend_valid_d = 1'b1;
          pc_d         = pc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 8'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a memory model backs the DUT, and a second
// instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, start, stop, stall, redirect, load_req;
  logic [7:0]  redirect_addr, load_addr;
  logic [31:0] load_data;
  logic [31:0] mem_rdata;

  logic        load_ack, mem_we, instr_valid, busy;
  logic [7:0]  mem_addr, instr_pc;
  logic [31:0] mem_wdata, instr;
  logic [15:0] fetch_count;

  logic        s_load_ack, s_mem_we, s_instr_valid, s_busy;
  logic [7:0]  s_mem_addr, s_instr_pc;
  logic [31:0] s_mem_wdata, s_instr;
  logic [1:0]  s_fetch_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [31:0] ld_tbl [3];
  logic [31:0] mem [256];
  bit          wr_v [256];

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(8'd0), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .load_req(load_req),
    .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .busy(busy),
    .fetch_count(fetch_count));

  fetch_controller #(.RESET_PC(8'd0), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .load_req(load_req),
    .load_addr(load_addr), .load_data(load_data), .load_ack(s_load_ack),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we), .mem_rdata(mem_rdata),
    .instr(s_instr), .instr_pc(s_instr_pc), .instr_valid(s_instr_valid), .busy(s_busy),
    .fetch_count(s_fetch_count));

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {24'hC0DE00, a};
  endfunction

  // Synchronous-read memory; unwritten words read back a fixed address pattern.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]  <= mem_wdata;
      wr_v[mem_addr] <= 1'b1;
    end
    mem_rdata <= wr_v[mem_addr] ? mem[mem_addr] : pat(mem_addr);
  end

  function automatic logic [31:0] exp_instr(input logic [7:0] a);
    return (a < 8'd3) ? ld_tbl[a[1:0]] : pat(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; load_req = 1'b1; load_addr = 8'h11;
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_load_ack: got %b want 0", load_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
    reset = 1'b0; start = 1'b0; load_req = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    tick();
  endtask

  task automatic test_load();
    load_req = 1'b1; load_addr = 8'd0; load_data = ld_tbl[0];
    #1;
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL load_idle_ack: got %b want 0", load_ack); end
    tick();
    for (int i = 0; i < 3; i++) begin
      load_addr = 8'(i); load_data = ld_tbl[i];
      #1;
      checks++; if (mem_we !== 1'b1 || load_ack !== 1'b1) begin errors++; $display("FAIL load_we_%0d: got we=%b ack=%b want 1/1", i, mem_we, load_ack); end
      checks++; if (mem_addr !== 8'(i)) begin errors++; $display("FAIL load_addr_%0d: got %0d want %0d", i, mem_addr, i); end
      checks++; if (mem_wdata !== ld_tbl[i]) begin errors++; $display("FAIL load_data_%0d: got %h want %h", i, mem_wdata, ld_tbl[i]); end
      tick();
    end
    load_req = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL load_end: got we=%b ack=%b want 0/0", mem_we, load_ack); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_sequential();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_first: got busy=%b valid=%b want 1/0", busy, instr_valid); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL seq_first_addr: got %0d want 0", mem_addr); end
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k)) begin errors++; $display("FAIL seq_pc_%0d: got valid=%b pc=%0d want 1/%0d", k, instr_valid, instr_pc, k); end
      checks++; if (instr !== exp_instr(8'(k))) begin errors++; $display("FAIL seq_instr_%0d: got %h want %h", k, instr, exp_instr(8'(k))); end
      checks++; if (fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL seq_count_%0d: got %0d want %0d", k, fetch_count, exp_cnt); end
      tick();
      exp_cnt++;
    end
    checks++; if (fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL seq_count_end: got %0d want %0d", fetch_count, exp_cnt); end
    checks++; if (s_fetch_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", s_fetch_count); end
  endtask

  task automatic test_stall();
    redirect = 1'b1; redirect_addr = 8'd3;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (instr_pc !== 8'd3 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_pre: got pc=%0d valid=%b want 3/1", instr_pc, instr_valid); end
    tick();
    exp_cnt++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (instr_pc !== 8'd4 || mem_addr !== 8'd4) begin errors++; $display("FAIL stall_hold_%0d: got pc=%0d addr=%0d want 4/4", i, instr_pc, mem_addr); end
      checks++; if (instr !== pat(8'd4)) begin errors++; $display("FAIL stall_instr_%0d: got %h want %h", i, instr, pat(8'd4)); end
      checks++; if (fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_count_%0d: got %0d want %0d", i, fetch_count, exp_cnt); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (instr_pc !== 8'd4 || mem_addr !== 8'd5) begin errors++; $display("FAIL stall_release: got pc=%0d addr=%0d want 4/5", instr_pc, mem_addr); end
    tick();
    exp_cnt++;
    checks++; if (instr_pc !== 8'd5 || fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stall_next: got pc=%0d cnt=%0d want 5/%0d", instr_pc, fetch_count, exp_cnt); end
  endtask

  task automatic test_redirect();
    for (int k = 5; k < 10; k++) begin
      checks++; if (instr_pc !== 8'(k)) begin errors++; $display("FAIL redir_walk_%0d: got %0d want %0d", k, instr_pc, k); end
      tick();
      exp_cnt++;
    end
    redirect = 1'b1; redirect_addr = 8'd7;
    #1;
    checks++; if (instr_pc !== 8'd10 || instr_valid !== 1'b1) begin errors++; $display("FAIL redir_at10: got pc=%0d valid=%b want 10/1", instr_pc, instr_valid); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_addr !== 8'd7) begin errors++; $display("FAIL redir_bubble: got valid=%b addr=%0d want 0/7", instr_valid, mem_addr); end
    checks++; if (fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL redir_count: got %0d want %0d", fetch_count, exp_cnt); end
    tick();
    checks++; if (instr_pc !== 8'd7 || instr_valid !== 1'b1 || instr !== pat(8'd7)) begin errors++; $display("FAIL redir_pc7: got pc=%0d valid=%b instr=%h want 7/1/%h", instr_pc, instr_valid, instr, pat(8'd7)); end
    tick();
    exp_cnt++;
    checks++; if (instr_pc !== 8'd8) begin errors++; $display("FAIL redir_pc8: got %0d want 8", instr_pc); end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    tick();
    exp_cnt++;
    redirect = 1'b1; redirect_addr = 8'd254;
    tick();
    redirect = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      e = 8'(254 + i);
      checks++; if (instr_pc !== e || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc_%0d: got pc=%0d valid=%b want %0d/1", i, instr_pc, instr_valid, e); end
      checks++; if (instr !== exp_instr(e)) begin errors++; $display("FAIL wrap_instr_%0d: got %h want %h", i, instr, exp_instr(e)); end
      tick();
      exp_cnt++;
    end
    checks++; if (fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL wrap_count: got %0d want %0d", fetch_count, exp_cnt); end
    checks++; if (s_fetch_count !== 2'd3) begin errors++; $display("FAIL wrap_sat: got %0d want 3", s_fetch_count); end
  endtask

  task automatic test_stop();
    load_req = 1'b1; load_addr = 8'h55; load_data = 32'hDEADBEEF;
    #1;
    checks++; if (load_ack !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stop_load_ignored: got ack=%b we=%b busy=%b want 0/0/1", load_ack, mem_we, busy); end
    tick();
    exp_cnt++;
    load_req = 1'b0;
    stop = 1'b1; redirect = 1'b1; redirect_addr = 8'h20;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 8'h20) begin errors++; $display("FAIL stop_redir_first: got busy=%b valid=%b addr=%h want 1/0/20", busy, instr_valid, mem_addr); end
    tick();
    stop = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 8'h20) begin errors++; $display("FAIL stop_idle: got busy=%b valid=%b addr=%h want 0/0/20", busy, instr_valid, mem_addr); end
    checks++; if (fetch_count !== 16'(exp_cnt)) begin errors++; $display("FAIL stop_count: got %0d want %0d", fetch_count, exp_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b1) begin errors++; $display("FAIL midf_pre: got busy=%b valid=%b want 1/1", busy, instr_valid); end
    reset = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midf_during: got valid=%b busy=%b want 0/0", instr_valid, busy); end
    tick();
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 8'd0) begin errors++; $display("FAIL midf_after: got busy=%b valid=%b addr=%0d want 0/0/0", busy, instr_valid, mem_addr); end
    checks++; if (fetch_count !== 16'd0 || s_fetch_count !== 2'd0) begin errors++; $display("FAIL midf_count: got %0d/%0d want 0/0", fetch_count, s_fetch_count); end
    load_req = 1'b1; load_addr = 8'h40; load_data = 32'hA5A5A5A5;
    tick();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midl_pre: got we=%b want 1", mem_we); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || load_ack !== 1'b0) begin errors++; $display("FAIL midl_during: got we=%b ack=%b want 0/0", mem_we, load_ack); end
    tick();
    reset = 1'b0; load_req = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midl_after: got busy=%b we=%b want 0/0", busy, mem_we); end
    tick();
    start = 1'b1; load_req = 1'b1; load_addr = 8'd200; load_data = 32'h12345678;
    #1;
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL both_idle_ack: got %b want 0", load_ack); end
    tick();
    checks++; if (busy !== 1'b1 || mem_we !== 1'b1 || load_ack !== 1'b1 || mem_addr !== 8'd200) begin errors++; $display("FAIL both_load: got busy=%b we=%b ack=%b addr=%0d want 1/1/1/200", busy, mem_we, load_ack, mem_addr); end
    start = 1'b0; load_req = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    ld_tbl[0] = 32'h38010005;
    ld_tbl[1] = 32'h38020009;
    ld_tbl[2] = 32'h00221826;
    reset = 1'b1; start = 1'b0; stop = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_addr = 8'd0; load_req = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    test_reset();
    test_load();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_stop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
